// File: rtl/checker_pkg.sv
// Shared types and helpers for the register-file commit checker.
// Holds the checker state encoding and a saturating increment.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Increments value but sticks at the all-ones pattern of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the architectural register file, fed from the snooped writeback port.
// Register 0 always reads as zero; out-of-range destinations are dropped.
module shadow_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam logic [IDX_W:0] LP_NUM_REGS = (IDX_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_ok;
  logic              w_rd_ok;

  assign w_wr_ok = i_we && (i_waddr != '0) && ({1'b0, i_waddr} < LP_NUM_REGS);
  assign w_rd_ok = (i_raddr != '0) && ({1'b0, i_raddr} < LP_NUM_REGS);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_ok ? r_regs[i_raddr] : '0;

endmodule

// File: rtl/regfile_commit_checker.sv
// Runs the snooped processor for a fixed cycle budget, then scans the shadow file against
// a loadable expected/care table. Optional early stop input under CHECKER_EARLY_STOP_EN.
module regfile_commit_checker
  import checker_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int IDX_W       = 5,
  parameter int CYCLE_LIMIT = 1000,
  parameter int ERR_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_wr_en,
  input  logic [IDX_W-1:0]  exp_wr_idx,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic              exp_wr_care,
  input  logic              rf_write_enable,
  input  logic [IDX_W-1:0]  rf_write_ctrl,
  input  logic [DATA_W-1:0] rf_write_data,
`ifdef CHECKER_EARLY_STOP_EN
  input  logic              halt,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [31:0]       cycle_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam logic [IDX_W:0]   LP_NUM_REGS = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [31:0]      LP_LAST_CYC = 32'(CYCLE_LIMIT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_cycle_count;
  logic [ERR_W-1:0]    r_error_count;
  logic [IDX_W-1:0]    r_scan;
  logic [IDX_W-1:0]    r_first_err_idx;
  logic [DATA_W-1:0]   r_first_err_exp;
  logic [DATA_W-1:0]   r_first_err_got;
  logic [DATA_W-1:0]   r_exp_data [NUM_REGS];
  logic [NUM_REGS-1:0] r_exp_care;

  logic                w_idle_or_done;
  logic                w_start_run;
  logic                w_exp_we;
  logic                w_snoop_we;
  logic                w_shadow_clr;
  logic                w_halt;
  logic                w_mismatch;
  logic [DATA_W-1:0]   w_shadow_rd;

`ifdef CHECKER_EARLY_STOP_EN
  assign w_halt = halt;
`else
  assign w_halt = 1'b0;
`endif

  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
  assign w_start_run    = start && w_idle_or_done;
  assign w_exp_we       = exp_wr_en && w_idle_or_done && ({1'b0, exp_wr_idx} < LP_NUM_REGS);
  assign w_snoop_we     = rf_write_enable && (r_state == RUN);
  // A new run always begins from an all-zero shadow, like a freshly reset core.
  assign w_shadow_clr   = reset || w_start_run;
  assign w_mismatch     = (r_state == CHECK) && r_exp_care[r_scan] &&
                          (w_shadow_rd != r_exp_data[r_scan]);

  shadow_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_shadow (
    .i_clk   (clock),
    .i_clr   (w_shadow_clr),
    .i_we    (w_snoop_we),
    .i_waddr (rf_write_ctrl),
    .i_wdata (rf_write_data),
    .i_raddr (r_scan),
    .o_rdata (w_shadow_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_next = RUN;
      RUN:        if (w_halt || (r_cycle_count == LP_LAST_CYC)) w_state_next = CHECK;
      CHECK:      if (r_scan == LP_LAST_IDX) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_exp_care <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_exp_data[i] <= '0;
      end
    end else if (w_exp_we) begin
      r_exp_care[exp_wr_idx] <= exp_wr_care;
      r_exp_data[exp_wr_idx] <= exp_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle_count   <= '0;
      r_error_count   <= '0;
      r_scan          <= '0;
      r_first_err_idx <= '0;
      r_first_err_exp <= '0;
      r_first_err_got <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_cycle_count   <= '0;
            r_error_count   <= '0;
            r_scan          <= '0;
            r_first_err_idx <= '0;
            r_first_err_exp <= '0;
            r_first_err_got <= '0;
          end
        end
        RUN: r_cycle_count <= r_cycle_count + 32'd1;
        CHECK: begin
          r_scan <= r_scan + IDX_W'(1);
          if (w_mismatch) begin
            r_error_count <= ERR_W'(sat_inc(32'(r_error_count), ERR_W));
            // Zero count means this is the lowest-index mismatch of the scan.
            if (r_error_count == '0) begin
              r_first_err_idx <= r_scan;
              r_first_err_exp <= r_exp_data[r_scan];
              r_first_err_got <= w_shadow_rd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state == RUN) || (r_state == CHECK);
  assign done          = (r_state == DONE);
  assign pass          = (r_state == DONE) && (r_error_count == '0);
  assign error_count   = r_error_count;
  assign cycle_count   = r_cycle_count;
  assign first_err_idx = r_first_err_idx;
  assign first_err_exp = r_first_err_exp;
  assign first_err_got = r_first_err_got;

endmodule

// File: tb/tb_regfile_commit_checker.sv
// Randomised bench for regfile_commit_checker against a table-level reference model.
// A second instance with a 2-bit error counter covers saturation.
module tb_regfile_commit_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IW = 5;
  localparam int CL = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start, exp_wr_en, exp_wr_care, rf_write_enable;
  logic [IW-1:0] exp_wr_idx, rf_write_ctrl;
  logic [DW-1:0] exp_wr_data, rf_write_data;
`ifdef CHECKER_EARLY_STOP_EN
  logic          halt;
`endif

  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [31:0]   cycle_count;
  logic [IW-1:0] first_err_idx;
  logic [DW-1:0] first_err_exp, first_err_got;

  logic          s_busy, s_done, s_pass;
  logic [1:0]    s_error_count;
  logic [31:0]   s_cycle_count;
  logic [IW-1:0] s_first_err_idx;
  logic [DW-1:0] s_first_err_exp, s_first_err_got;

  regfile_commit_checker #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .CYCLE_LIMIT(CL), .ERR_W(16)) u_dut (
    .clock(clock), .reset(reset), .start(start),
    .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx), .exp_wr_data(exp_wr_data), .exp_wr_care(exp_wr_care),
    .rf_write_enable(rf_write_enable), .rf_write_ctrl(rf_write_ctrl), .rf_write_data(rf_write_data),
`ifdef CHECKER_EARLY_STOP_EN
    .halt(halt),
`endif
    .busy(busy), .done(done), .pass(pass), .error_count(error_count), .cycle_count(cycle_count),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  regfile_commit_checker #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .CYCLE_LIMIT(CL), .ERR_W(2)) u_dut_sat (
    .clock(clock), .reset(reset), .start(start),
    .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx), .exp_wr_data(exp_wr_data), .exp_wr_care(exp_wr_care),
    .rf_write_enable(rf_write_enable), .rf_write_ctrl(rf_write_ctrl), .rf_write_data(rf_write_data),
`ifdef CHECKER_EARLY_STOP_EN
    .halt(halt),
`endif
    .busy(s_busy), .done(s_done), .pass(s_pass), .error_count(s_error_count), .cycle_count(s_cycle_count),
    .first_err_idx(s_first_err_idx), .first_err_exp(s_first_err_exp), .first_err_got(s_first_err_got)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected/care table, shadow contents and a per-cycle snoop script.
  logic [DW-1:0] m_exp    [NR];
  bit            m_care   [NR];
  logic [DW-1:0] m_shadow [NR];
  bit            sn_en    [CL];
  logic [IW-1:0] sn_idx   [CL];
  logic [DW-1:0] sn_data  [CL];
  int            halt_at  = -1;
  bit            ck_force = 1'b0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic idle_inputs;
    start = 1'b0; exp_wr_en = 1'b0; exp_wr_idx = '0; exp_wr_data = '0; exp_wr_care = 1'b0;
    rf_write_enable = 1'b0; rf_write_ctrl = '0; rf_write_data = '0;
`ifdef CHECKER_EARLY_STOP_EN
    halt = 1'b0;
`endif
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_exp[i] = '0;
      m_care[i] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_errs"}, 64'(error_count), 64'd0);
    chk({tag, "_cyc"}, 64'(cycle_count), 64'd0);
    chk({tag, "_fidx"}, 64'(first_err_idx), 64'd0);
    chk({tag, "_fexp"}, 64'(first_err_exp), 64'd0);
    chk({tag, "_fgot"}, 64'(first_err_got), 64'd0);
    chk({tag, "_serrs"}, 64'(s_error_count), 64'd0);
  endtask

  // Snoop traffic during a load is ignored; it is there to disturb the table write path.
  task automatic load(input int idx, input logic [DW-1:0] data, input bit care);
    exp_wr_en = 1'b1; exp_wr_idx = IW'(idx); exp_wr_data = data; exp_wr_care = care;
    rf_write_enable = 1'($urandom_range(0, 1)); rf_write_ctrl = IW'($urandom_range(1, NR - 1));
    rf_write_data = $urandom;
    tick();
    idle_inputs();
    m_exp[idx] = data;
    m_care[idx] = care;
  endtask

  task automatic clear_snoops;
    for (int c = 0; c < CL; c++) begin
      sn_en[c] = 1'b0; sn_idx[c] = '0; sn_data[c] = '0;
    end
  endtask

  task automatic fill_snoops;
    for (int c = 0; c < CL; c++) begin
      sn_en[c]   = 1'($urandom_range(0, 1));
      sn_idx[c]  = IW'($urandom_range(0, NR - 1));
      sn_data[c] = ($urandom_range(0, 3) == 0) ? $urandom : DW'($urandom_range(0, 3));
    end
  endtask

  task automatic random_loads;
    int n;
    n = $urandom_range(0, 6);
    for (int j = 0; j < n; j++) begin
      load($urandom_range(0, NR - 1), DW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_and_check(input string name);
    int run_len, k, errs, first, sat_errs;
    for (int i = 0; i < NR; i++) m_shadow[i] = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_cyc0", 64'(cycle_count), 64'd0);
    run_len = CL;
    for (int c = 0; c < CL; c++) begin
      rf_write_enable = sn_en[c]; rf_write_ctrl = sn_idx[c]; rf_write_data = sn_data[c];
      exp_wr_en = 1'($urandom_range(0, 1)); exp_wr_idx = IW'($urandom_range(0, NR - 1));
      exp_wr_data = $urandom; exp_wr_care = 1'b1;
      start = ($urandom_range(0, 3) == 0);
`ifdef CHECKER_EARLY_STOP_EN
      halt = (c == halt_at);
`endif
      tick();
      if (sn_en[c] && sn_idx[c] != '0) m_shadow[sn_idx[c]] = sn_data[c];
      if (c == halt_at) begin
        run_len = c + 1;
        break;
      end
    end
    idle_inputs();
    chk("run_cyc_end", 64'(cycle_count), 64'(run_len));
    chk("chk_busy", 64'(busy), 64'd1);
    k = 0;
    while (!done && k < NR + 20) begin
      if (ck_force) begin
        rf_write_enable = 1'b1; rf_write_ctrl = IW'(4); rf_write_data = DW'(2);
      end else begin
        rf_write_enable = 1'($urandom_range(0, 1)); rf_write_ctrl = IW'($urandom_range(0, NR - 1));
        rf_write_data = $urandom;
      end
      exp_wr_en = 1'($urandom_range(0, 1)); exp_wr_idx = IW'($urandom_range(0, NR - 1));
      exp_wr_data = $urandom; exp_wr_care = 1'b1;
      start = ($urandom_range(0, 3) == 0);
      tick();
      k++;
    end
    idle_inputs();
    errs = 0;
    first = 0;
    for (int i = 0; i < NR; i++) begin
      if (m_care[i] && m_shadow[i] !== m_exp[i]) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
    sat_errs = (errs > 3) ? 3 : errs;
    chk("check_latency", 64'(k), 64'(NR));
    chk("done", 64'(done), 64'd1);
    chk("busy_done", 64'(busy), 64'd0);
    chk("pass", 64'(pass), 64'(errs == 0));
    chk("error_count", 64'(error_count), 64'(errs));
    chk("cycle_count", 64'(cycle_count), 64'(run_len));
    chk("first_err_idx", 64'(first_err_idx), 64'(first));
    chk("first_err_exp", 64'(first_err_exp), (errs > 0) ? 64'(m_exp[first]) : 64'd0);
    chk("first_err_got", 64'(first_err_got), (errs > 0) ? 64'(m_shadow[first]) : 64'd0);
    chk("sat_error_count", 64'(s_error_count), 64'(sat_errs));
    chk("sat_pass", 64'(s_pass), 64'(errs == 0));
    $display("run %s: len=%0d errs=%0d first=%0d pass=%0d", name, run_len, errs, first, pass);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();

    // Single cared register written mid-run with the right value.
    do_reset();
    check_zero("reset");
    load(1, 32'd5, 1'b1);
    clear_snoops();
    sn_en[3] = 1'b1; sn_idx[3] = IW'(1); sn_data[3] = 32'd5;
    run_and_check("r1_match");

    // One wrong value: r3 gets 8 where 9 is expected.
    do_reset();
    load(2, 32'd7, 1'b1);
    load(3, 32'd9, 1'b1);
    clear_snoops();
    sn_en[1] = 1'b1; sn_idx[1] = IW'(2); sn_data[1] = 32'd7;
    sn_en[2] = 1'b1; sn_idx[2] = IW'(3); sn_data[2] = 32'd8;
    run_and_check("r3_mismatch");

    // Writes to r0 never land.
    do_reset();
    load(0, 32'd0, 1'b1);
    clear_snoops();
    sn_en[4] = 1'b1; sn_idx[4] = '0; sn_data[4] = 32'hFFFF_FFFF;
    run_and_check("r0_write");

    // Write on the last RUN cycle lands; writes during CHECK do not.
    do_reset();
    load(4, 32'd1, 1'b1);
    clear_snoops();
    sn_en[CL-1] = 1'b1; sn_idx[CL-1] = IW'(4); sn_data[CL-1] = 32'd1;
    ck_force = 1'b1;
    run_and_check("last_cycle");
    ck_force = 1'b0;

    // Four mismatches saturate the 2-bit counter.
    do_reset();
    for (int i = 5; i < 9; i++) load(i, DW'(10 + i), 1'b1);
    clear_snoops();
    run_and_check("saturate");

    // Reset in the middle of CHECK aborts the run and wipes the table.
    do_reset();
    load(1, 32'd3, 1'b1);
    fill_snoops();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < CL + 5; c++) tick();
    chk("mid_check_busy", 64'(busy), 64'd1);
    do_reset();
    check_zero("abort");
    fill_snoops();
    run_and_check("after_abort");

`ifdef CHECKER_EARLY_STOP_EN
    do_reset();
    load(2, 32'd1, 1'b1);
    fill_snoops();
    halt_at = 2;
    run_and_check("halt");
    halt_at = -1;
`endif

    // Back-to-back runs from DONE: table retained, shadow cleared each time.
    do_reset();
    for (int r = 0; r < 25; r++) begin
      random_loads();
      fill_snoops();
      run_and_check($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
